// File: rtl/pc_gen.sv
// pc_gen: architectural PC register with trap > jump > branch redirects, stall buffering
// and misaligned-target reporting. Optional macro PC_COMPRESSED_EN enables 2-byte instructions.
module pc_gen #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          INC          = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
`ifdef PC_COMPRESSED_EN
  input  logic            is_compressed,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            redirect_pending,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pending_target, pending_next, pc_next;
  logic [XLEN-1:0] trap_addr, jb_target, cand;
  logic            jb_req, jb_misaligned, cand_valid;

`ifdef PC_COMPRESSED_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
  assign pc_plus_inc = pc + (is_compressed ? XLEN'(2) : XLEN'(INC));
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
  assign pc_plus_inc = pc + XLEN'(INC);
`endif

  // A misaligned jump/branch is turned into a redirect to the trap handler.
  assign trap_addr     = trap_vector & ~ALIGN_MASK;
  assign jb_req        = jump | branch_taken;
  assign jb_target     = jump ? jump_target : branch_target;
  assign jb_misaligned = !trap && jb_req && ((jb_target & ALIGN_MASK) != '0);
  assign cand_valid    = trap | jb_req;
  assign cand          = (trap || jb_misaligned) ? trap_addr : jb_target;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_target;
    case (state)
      RUN: begin
        if (!stall) begin
          pc_next = cand_valid ? cand : pc_plus_inc;
        end else if (cand_valid) begin
          pending_next = cand;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        // Only a real trap may displace a buffered redirect.
        if (stall) begin
          if (trap) pending_next = trap_addr;
        end else begin
          pc_next    = trap ? trap_addr : pending_target;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pending_target <= '0;
      misalign_err   <= 1'b0;
      misalign_addr  <= '0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pending_target <= pending_next;
      misalign_err   <= jb_misaligned;
      if (jb_misaligned) misalign_addr <= jb_target;
    end
  end

  assign redirect_pending = (state == HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen, checked against
// a rule-level reference model of the PC, the pending redirect and misalignment reporting.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_1000;
  localparam int unsigned INC  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, trap = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, trap_vector = '0;
`ifdef PC_COMPRESSED_EN
  logic        is_compressed = 1'b0;
`endif
  logic [31:0] pc, pc_plus_inc, misalign_addr;
  logic        redirect_pending, misalign_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc = '0, m_pend = '0, m_addr = '0;
  logic        m_hold = 1'b0, m_err = 1'b0;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .INC(INC)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .trap(trap),
    .trap_vector(trap_vector),
`ifdef PC_COMPRESSED_EN
    .is_compressed(is_compressed),
`endif
    .pc(pc),
    .pc_plus_inc(pc_plus_inc),
    .redirect_pending(redirect_pending),
    .misalign_err(misalign_err),
    .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] align_mask();
`ifdef PC_COMPRESSED_EN
    return 32'h1;
`else
    return 32'h3;
`endif
  endfunction

  function automatic logic [31:0] inc_amount();
`ifdef PC_COMPRESSED_EN
    return is_compressed ? 32'd2 : 32'(INC);
`else
    return 32'(INC);
`endif
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 4) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic set_idle();
    rst = 1'b0; stall = 1'b0; trap = 1'b0; jump = 1'b0; branch_taken = 1'b0;
`ifdef PC_COMPRESSED_EN
    is_compressed = 1'b0;
`endif
  endtask

  // Advance one clock, applying the architectural rules to the model at the edge.
  task automatic step();
    logic [31:0] tv, jb, tgt;
    logic        bad, have;
    @(posedge clk);
    if (rst) begin
      m_pc = RV; m_hold = 1'b0; m_pend = '0; m_err = 1'b0; m_addr = '0;
    end else begin
      tv   = trap_vector & ~align_mask();
      jb   = jump ? jump_target : branch_target;
      bad  = !trap && (jump || branch_taken) && ((jb & align_mask()) != 32'h0);
      have = trap || jump || branch_taken;
      tgt  = (trap || bad) ? tv : jb;
      if (!m_hold) begin
        if (!stall) m_pc = have ? tgt : m_pc + inc_amount();
        else if (have) begin m_hold = 1'b1; m_pend = tgt; end
      end else if (stall) begin
        if (trap) m_pend = tv;
      end else begin
        m_pc = trap ? tv : m_pend;
        m_hold = 1'b0;
      end
      m_err = bad;
      if (bad) m_addr = jb;
    end
    #1;
  endtask

  task automatic test_reset();
    set_idle(); rst = 1'b1; step(); rst = 1'b0;
    checks++; if (pc !== RV) begin errors++; $display("[TB] FAIL reset_pc got %h want %h", pc, RV); end
    checks++; if (redirect_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got %b want 0", redirect_pending); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", misalign_err); end
    checks++; if (misalign_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", misalign_addr); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== RV + 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_pc%0d got %h want %h", i, pc, RV + 32'(4 * i)); end
      checks++; if (redirect_pending !== 1'b0) begin errors++; $display("[TB] FAIL seq_pending%0d got %b want 0", i, redirect_pending); end
    end
    checks++; if (pc_plus_inc !== 32'h0000_1010) begin errors++; $display("[TB] FAIL seq_plus got %h want 00001010", pc_plus_inc); end
  endtask

  task automatic test_priority();
    set_idle();
    trap = 1'b1; trap_vector = 32'h200; jump = 1'b1; jump_target = 32'h3000;
    branch_taken = 1'b1; branch_target = 32'h4000;
    step();
    checks++; if (pc !== 32'h200) begin errors++; $display("[TB] FAIL prio_trap got %h want 00000200", pc); end
    trap = 1'b0;
    step();
    checks++; if (pc !== 32'h3000) begin errors++; $display("[TB] FAIL prio_jump got %h want 00003000", pc); end
    set_idle();
  endtask

  task automatic test_stall();
    set_idle();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h800;
    for (int i = 0; i < 3; i++) begin
      step();
      branch_taken = 1'b0;
      checks++; if (pc !== 32'h3000) begin errors++; $display("[TB] FAIL stall_pc%0d got %h want 00003000", i, pc); end
      checks++; if (redirect_pending !== 1'b1) begin errors++; $display("[TB] FAIL stall_pending%0d got %b want 1", i, redirect_pending); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h800) begin errors++; $display("[TB] FAIL release_pc got %h want 00000800", pc); end
    checks++; if (redirect_pending !== 1'b0) begin errors++; $display("[TB] FAIL release_pending got %b want 0", redirect_pending); end
    step();
    checks++; if (pc !== 32'h804) begin errors++; $display("[TB] FAIL after_release got %h want 00000804", pc); end
  endtask

  task automatic test_trap_override();
    set_idle();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h800; step();
    branch_taken = 1'b0; trap = 1'b1; trap_vector = 32'h100; step();
    trap = 1'b0; stall = 1'b0; step();
    checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL hold_trap got %h want 00000100", pc); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h800; step();
    branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h5000; step();
    jump = 1'b0; stall = 1'b0; step();
    checks++; if (pc !== 32'h800) begin errors++; $display("[TB] FAIL hold_jump_drop got %h want 00000800", pc); end
  endtask

  task automatic test_misaligned();
    set_idle();
    jump = 1'b1; jump_target = 32'h2002; trap_vector = 32'h103; step();
`ifdef PC_COMPRESSED_EN
    checks++; if (pc !== 32'h2002) begin errors++; $display("[TB] FAIL c_accept got %h want 00002002", pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL c_accept_err got %b want 0", misalign_err); end
    jump_target = 32'h2001; step();
    checks++; if (pc !== 32'h102) begin errors++; $display("[TB] FAIL c_fault_pc got %h want 00000102", pc); end
    checks++; if (misalign_addr !== 32'h2001) begin errors++; $display("[TB] FAIL c_fault_addr got %h want 00002001", misalign_addr); end
`else
    checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL mis_pc got %h want 00000100", pc); end
    checks++; if (misalign_addr !== 32'h2002) begin errors++; $display("[TB] FAIL mis_addr got %h want 00002002", misalign_addr); end
`endif
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_err got %b want 1", misalign_err); end
    jump = 1'b0; step();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL mis_err_pulse got %b want 0", misalign_err); end
    // Misalignment is reported even while stalled.
    stall = 1'b1; jump = 1'b1; jump_target = 32'h3001; step();
    jump = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_stall_err got %b want 1", misalign_err); end
    checks++; if (misalign_addr !== 32'h3001) begin errors++; $display("[TB] FAIL mis_stall_addr got %h want 00003001", misalign_addr); end
    checks++; if (pc !== m_pc) begin errors++; $display("[TB] FAIL mis_stall_hold got %h want %h", pc, m_pc); end
    stall = 1'b0; step();
    checks++; if (pc !== (32'h103 & ~align_mask())) begin errors++; $display("[TB] FAIL mis_stall_release got %h want %h", pc, 32'h103 & ~align_mask()); end
  endtask

  task automatic test_wrap_reset();
    set_idle();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC; step(); jump = 1'b0;
    checks++; if (pc_plus_inc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_plus got %h want 00000000", pc_plus_inc); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h want 00000000", pc); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h800; step();
    branch_taken = 1'b0;
    checks++; if (redirect_pending !== 1'b1) begin errors++; $display("[TB] FAIL rst_hold_pending got %b want 1", redirect_pending); end
    stall = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    checks++; if (pc !== RV) begin errors++; $display("[TB] FAIL rst_hold_pc got %h want %h", pc, RV); end
    checks++; if (redirect_pending !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold_clear got %b want 0", redirect_pending); end
    step();
    checks++; if (pc !== RV + 32'd4) begin errors++; $display("[TB] FAIL rst_hold_lost got %h want %h", pc, RV + 32'd4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst           = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      trap          = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      trap_vector   = $urandom;
      jump_target   = rand_target();
      branch_target = rand_target();
`ifdef PC_COMPRESSED_EN
      is_compressed = 1'($urandom_range(0, 1));
`endif
      step();
      checks++; if (pc !== m_pc) begin errors++; $display("[TB] FAIL rnd_pc[%0d] got %h want %h", i, pc, m_pc); end
      checks++; if (pc_plus_inc !== m_pc + inc_amount()) begin errors++; $display("[TB] FAIL rnd_plus[%0d] got %h want %h", i, pc_plus_inc, m_pc + inc_amount()); end
      checks++; if (redirect_pending !== m_hold) begin errors++; $display("[TB] FAIL rnd_pending[%0d] got %b want %b", i, redirect_pending, m_hold); end
      checks++; if (misalign_err !== m_err) begin errors++; $display("[TB] FAIL rnd_err[%0d] got %b want %b", i, misalign_err, m_err); end
      if (m_err) begin
        checks++; if (misalign_addr !== m_addr) begin errors++; $display("[TB] FAIL rnd_addr[%0d] got %h want %h", i, misalign_addr, m_addr); end
      end
    end
    set_idle();
  endtask

  initial begin
    $display("[TB] starting pc_gen bench");
    test_reset();
    test_priority();
    test_stall();
    test_trap_override();
    test_misaligned();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
